// File: rtl/and_reduce_pipe.sv
// Pipelined N_IN-operand bitwise AND (optionally NAND) reduction tree with
// valid/ready handshaking and a side-band partial result (operand0 & operand1).
module and_reduce_pipe #(
    parameter int N_IN  = 3,
    parameter int WIDTH = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_IN*WIDTH-1:0]   in_data,
    input  logic                    in_invert,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [WIDTH-1:0]        out_partial
);

    localparam int LEVELS = (N_IN <= 1) ? 1 : $clog2(N_IN);
    localparam int NPAD   = 1 << LEVELS;

    logic                adv;
    logic [WIDTH-1:0]    leaf   [NPAD];
    logic [WIDTH-1:0]    node_d [1:NPAD-1];
    logic [WIDTH-1:0]    node_q [1:NPAD-1];
    logic [WIDTH-1:0]    part_d;
    logic [WIDTH-1:0]    part_q [1:LEVELS];
    logic [LEVELS:1]     vld_q;
    logic                inv_final;

    assign adv         = !out_valid || out_ready;
    assign in_ready    = adv;
    assign out_valid   = vld_q[LEVELS];
    assign out_data    = node_q[1];
    assign out_partial = part_q[LEVELS];

    // Missing operands are padded with all-ones so they never affect the AND.
    for (genvar k = 0; k < NPAD; k++) begin : g_leaf
        if (k < N_IN) begin : g_op
            assign leaf[k] = in_data[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign leaf[k] = '1;
        end
    end

    if (N_IN == 1) begin : g_part1
        assign part_d = in_data[WIDTH-1:0];
    end else begin : g_partn
        assign part_d = in_data[WIDTH-1:0] & in_data[2*WIDTH-1:WIDTH];
    end

    // Heap-ordered tree: node i = node 2i & node 2i+1; indices >= NPAD are the
    // input leaves. Node 1 is the final rank and is the only one inverted.
    for (genvar i = 1; i < NPAD; i++) begin : g_node
        logic [WIDTH-1:0] lhs;
        logic [WIDTH-1:0] rhs;
        if (2*i >= NPAD) begin : g_from_leaf
            assign lhs = leaf[2*i-NPAD];
            assign rhs = leaf[2*i+1-NPAD];
        end else begin : g_from_node
            assign lhs = node_q[2*i];
            assign rhs = node_q[2*i+1];
        end
        if (i == 1) begin : g_root
            assign node_d[i] = (lhs & rhs) ^ {WIDTH{inv_final}};
        end else begin : g_inner
            assign node_d[i] = lhs & rhs;
        end
    end

    // Invert flag rides through ranks 1..LEVELS-1 and is consumed entering the final rank.
    if (LEVELS == 1) begin : g_inv1
        assign inv_final = in_invert;
    end else begin : g_invn
        logic [LEVELS-1:1] inv_q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                inv_q <= '0;
            end else if (adv) begin
                inv_q[1] <= in_invert;
                for (int r = 2; r < LEVELS; r++) begin
                    inv_q[r] <= inv_q[r-1];
                end
            end
        end
        assign inv_final = inv_q[LEVELS-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 1; i < NPAD; i++) begin
                node_q[i] <= '0;
            end
            for (int r = 1; r <= LEVELS; r++) begin
                part_q[r] <= '0;
            end
        end else if (adv) begin
            vld_q[1]  <= in_valid;
            part_q[1] <= part_d;
            for (int r = 2; r <= LEVELS; r++) begin
                vld_q[r]  <= vld_q[r-1];
                part_q[r] <= part_q[r-1];
            end
            for (int i = 1; i < NPAD; i++) begin
                node_q[i] <= node_d[i];
            end
        end
    end

endmodule

// File: tb/tb_and_reduce_pipe.sv
// Directed bench for and_reduce_pipe: three instances (3x1, 5x8, 1x4) exercised
// for reset, truth table, NAND/padding, backpressure, bubbles and N_IN=1.
module tb_and_reduce_pipe;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic       a_in_valid, a_in_ready, a_in_invert, a_out_valid, a_out_ready;
    logic [2:0] a_in_data;
    logic [0:0] a_out_data, a_out_partial;

    logic        b_in_valid, b_in_ready, b_in_invert, b_out_valid, b_out_ready;
    logic [39:0] b_in_data;
    logic [7:0]  b_out_data, b_out_partial;

    logic       c_in_valid, c_in_ready, c_in_invert, c_out_valid, c_out_ready;
    logic [3:0] c_in_data;
    logic [3:0] c_out_data, c_out_partial;

    and_reduce_pipe #(.N_IN(3), .WIDTH(1)) u_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_invert(a_in_invert), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_data(a_out_data), .out_partial(a_out_partial));

    and_reduce_pipe #(.N_IN(5), .WIDTH(8)) u_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_invert(b_in_invert), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_data(b_out_data), .out_partial(b_out_partial));

    and_reduce_pipe #(.N_IN(1), .WIDTH(4)) u_c (
        .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_invert(c_in_invert), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .out_data(c_out_data), .out_partial(c_out_partial));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_a_valid got %0h want 0", a_out_valid); end
        checks++; if (a_out_data !== 1'b0) begin errors++; $display("FAIL rst_a_data got %0h want 0", a_out_data); end
        checks++; if (a_out_partial !== 1'b0) begin errors++; $display("FAIL rst_a_partial got %0h want 0", a_out_partial); end
        checks++; if (b_out_valid !== 1'b0 || b_out_data !== 8'h00) begin errors++; $display("FAIL rst_b got v=%0h d=%0h want 0/0", b_out_valid, b_out_data); end
        checks++; if (c_out_valid !== 1'b0 || c_out_partial !== 4'h0) begin errors++; $display("FAIL rst_c got v=%0h p=%0h want 0/0", c_out_valid, c_out_partial); end
        rst_n = 1'b1;
        tick();
        a_in_valid = 1'b1; a_in_data = 3'b111;
        tick();
        tick();
        a_in_valid = 1'b0;
        checks++; if (a_out_valid !== 1'b1 || a_out_data !== 1'b1) begin errors++; $display("FAIL inflight_valid got v=%0h d=%0h want 1/1", a_out_valid, a_out_data); end
        #3 rst_n = 1'b0;
        #1;
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid got %0h want 0", a_out_valid); end
        checks++; if (a_out_data !== 1'b0) begin errors++; $display("FAIL async_rst_data got %0h want 0", a_out_data); end
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL stale_after_rst cyc %0d got %0h want 0", i, a_out_valid); end
        end
    endtask

    task automatic test_truth_table();
        logic [7:0] tt_d;
        logic [7:0] tt_p;
        int         v;
        tt_d = 8'h80;
        tt_p = 8'h88;
        a_out_ready = 1'b1;
        for (int t = 0; t < 10; t++) begin
            if (t < 8) begin a_in_valid = 1'b1; a_in_data = 3'(t); end
            else a_in_valid = 1'b0;
            tick();
            checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL tt_in_ready t=%0d got %0h want 1", t, a_in_ready); end
            if (t == 0 || t == 9) begin
                checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL tt_idle t=%0d got %0h want 0", t, a_out_valid); end
            end else begin
                v = t - 1;
                checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL tt_valid in=%0d got %0h want 1", v, a_out_valid); end
                checks++; if (a_out_data !== tt_d[v]) begin errors++; $display("FAIL tt_data in=%0d got %0h want %0h", v, a_out_data, tt_d[v]); end
                checks++; if (a_out_partial !== tt_p[v]) begin errors++; $display("FAIL tt_partial in=%0d got %0h want %0h", v, a_out_partial, tt_p[v]); end
            end
        end
    endtask

    task automatic test_nand_padding();
        b_out_ready = 1'b1;
        b_in_data   = {8'h3C, 8'hFF, 8'hFF, 8'hF0, 8'hFF};
        for (int t = 0; t < 5; t++) begin
            b_in_valid  = (t < 2);
            b_in_invert = (t == 1);
            tick();
            if (t == 2) begin
                checks++; if (b_out_valid !== 1'b1 || b_out_data !== 8'h30) begin errors++; $display("FAIL and_pad got v=%0h d=%0h want 1/30", b_out_valid, b_out_data); end
                checks++; if (b_out_partial !== 8'hF0) begin errors++; $display("FAIL and_partial got %0h want f0", b_out_partial); end
            end else if (t == 3) begin
                checks++; if (b_out_valid !== 1'b1 || b_out_data !== 8'hCF) begin errors++; $display("FAIL nand_pad got v=%0h d=%0h want 1/cf", b_out_valid, b_out_data); end
                checks++; if (b_out_partial !== 8'hF0) begin errors++; $display("FAIL nand_partial got %0h want f0", b_out_partial); end
            end else begin
                checks++; if (b_out_valid !== 1'b0) begin errors++; $display("FAIL nand_latency t=%0d got %0h want 0", t, b_out_valid); end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [2:0] items [6];
        logic       exp_d [6];
        logic       exp_p [6];
        int         sent, got, stall;
        bit         first;
        logic       held;
        items = '{3'd7, 3'd3, 3'd7, 3'd6, 3'd7, 3'd5};
        exp_d = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_p = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        sent = 0; got = 0; stall = 0; first = 0; held = 1'b0;
        for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
            if (a_out_valid && !first) begin first = 1; stall = 4; held = a_out_data; end
            a_out_ready = (stall == 0);
            a_in_valid  = (sent < 6);
            a_in_data   = items[(sent < 6) ? sent : 0];
            #1;
            if (stall > 0) begin
                checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready stall=%0d got %0h want 0", stall, a_in_ready); end
                checks++; if (a_out_valid !== 1'b1 || a_out_data !== held) begin errors++; $display("FAIL bp_hold got v=%0h d=%0h want 1/%0h", a_out_valid, a_out_data, held); end
                stall--;
            end
            if (a_out_valid && a_out_ready) begin
                checks++; if (a_out_data !== exp_d[got] || a_out_partial !== exp_p[got]) begin errors++; $display("FAIL bp_item%0d got %0h/%0h want %0h/%0h", got, a_out_data, a_out_partial, exp_d[got], exp_p[got]); end
                got++;
            end
            if (a_in_valid && a_in_ready) sent++;
            tick();
        end
        checks++; if (got != 6) begin errors++; $display("FAIL bp_count got %0d want 6", got); end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        repeat (3) tick();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bp_dup got %0h want 0", a_out_valid); end
    endtask

    task automatic test_bubbles();
        bit         pat   [6];
        logic [2:0] items [4];
        logic       exp_d [4];
        logic       exp_p [4];
        int         slot, idx, got, simul;
        bit         rdy;
        pat   = '{1, 0, 1, 1, 0, 1};
        items = '{3'd7, 3'd3, 3'd5, 3'd7};
        exp_d = '{1'b1, 1'b0, 1'b0, 1'b1};
        exp_p = '{1'b1, 1'b1, 1'b0, 1'b1};
        slot = 0; idx = 0; got = 0; simul = 0; rdy = 1;
        for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
            a_out_ready = rdy;
            rdy = !rdy;
            if (slot < 6 && pat[slot]) begin a_in_valid = 1'b1; a_in_data = items[idx]; end
            else a_in_valid = 1'b0;
            #1;
            if (a_out_valid && a_out_ready) begin
                checks++; if (a_out_data !== exp_d[got] || a_out_partial !== exp_p[got]) begin errors++; $display("FAIL bub_item%0d got %0h/%0h want %0h/%0h", got, a_out_data, a_out_partial, exp_d[got], exp_p[got]); end
                got++;
            end
            if (a_in_valid && a_in_ready && a_out_valid && a_out_ready) simul++;
            if (slot < 6) begin
                if (!pat[slot]) slot++;
                else if (a_in_ready) begin slot++; idx++; end
            end
            tick();
        end
        checks++; if (got != 4) begin errors++; $display("FAIL bub_count got %0d want 4", got); end
        checks++; if (simul == 0) begin errors++; $display("FAIL bub_simultaneous got %0d want >0", simul); end
        a_in_valid = 1'b0; a_out_ready = 1'b1;
        repeat (3) tick();
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL bub_dup got %0h want 0", a_out_valid); end
    endtask

    task automatic test_n_in_one();
        c_out_ready = 1'b1;
        c_in_valid  = 1'b1;
        c_in_data   = 4'hA;
        tick();
        c_in_valid = 1'b0;
        checks++; if (c_out_valid !== 1'b1 || c_out_data !== 4'hA) begin errors++; $display("FAIL n1_data got v=%0h d=%0h want 1/a", c_out_valid, c_out_data); end
        checks++; if (c_out_partial !== 4'hA) begin errors++; $display("FAIL n1_partial got %0h want a", c_out_partial); end
        tick();
        checks++; if (c_out_valid !== 1'b0) begin errors++; $display("FAIL n1_drain got %0h want 0", c_out_valid); end
    endtask

    initial begin
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_data = '0; a_in_invert = 1'b0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_data = '0; b_in_invert = 1'b0; b_out_ready = 1'b1;
        c_in_valid = 1'b0; c_in_data = '0; c_in_invert = 1'b0; c_out_ready = 1'b1;
        test_reset();
        test_truth_table();
        test_nand_padding();
        test_backpressure();
        test_bubbles();
        test_n_in_one();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
